uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (legal 1..8).
REQ-002 SHALL have port: clk  input  1  single system clock, all logic on posedge.
REQ-003 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: wdata  input  8  byte from core to enqueue.
REQ-005 SHALL have port: we  input  1  write strobe, one byte per cycle high.
REQ-006 SHALL have port: full  output  1  FIFO holds DEPTH bytes.
REQ-007 SHALL have port: empty  output  1  FIFO holds 0 bytes.
REQ-008 SHALL have port: count  output  DEPTH_LOG2+1  current occupancy.
REQ-009 SHALL have port: sdata  output  8  byte presented to the UART transmitter.
REQ-010 SHALL have port: tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port: tx_busy  input  1  transmitter busy; rises the cycle after tx_start is sampled, falls at end of stop bit.

Function
REQ-012 SHALL accept a write when we=1 and full=0; we=1 with full=1 SHALL drop the byte, leaving contents unchanged.
REQ-013 SHALL base full on the registered occupancy; a write while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-014 SHALL, on simultaneous accepted write and pop, leave count unchanged and store the new byte.
REQ-015 SHALL wrap read/write pointers modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-016 SHALL run FSM states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if empty=0 and tx_busy=0, SHALL in that cycle pop the head byte into sdata, assert tx_start for one cycle and move to WAIT_BUSY.
REQ-018 WAIT_BUSY: tx_start=0; SHALL move to WAIT_DONE on the first cycle tx_busy=1, else stay.
REQ-019 WAIT_DONE: SHALL return to IDLE on the first cycle tx_busy=0.
REQ-020 SHALL hold sdata stable from the tx_start cycle until the next pop.
REQ-021 SHALL never assert tx_start in two consecutive cycles nor outside IDLE.
REQ-022 Latency: a byte written into an empty FIFO with FSM in IDLE and tx_busy=0 SHALL appear with tx_start 2 cycles after the we cycle.
REQ-023 Bytes SHALL be transmitted in write order.

Reset
REQ-024 SHALL, on rstn=0 at any time, asynchronously clear: pointers, count=0, empty=1, full=0, sdata=8'h00, tx_start=0, state=IDLE, ovf=0; contents of in-flight transmission are abandoned.
REQ-025 Storage array SHALL need no reset.

Configuration
REQ-026 Macro UART_TX_BUFFER_OVF_EN SHALL, when defined, add ports ovf (output 1, sticky, set on any dropped write) and ovf_clr (input 1, clears ovf; set wins if simultaneous).
REQ-027 Without UART_TX_BUFFER_OVF_EN those ports SHALL be absent and dropped writes SHALL be silently discarded.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state typedef (IDLE/WAIT_BUSY/WAIT_DONE) and default DEPTH_LOG2 constant.
REQ-029 FIFO storage/pointers SHALL be one sub-module fifo_sync (params WIDTH=8, DEPTH_LOG2); FSM and tx handshake stay in uart_tx_buffer.

Verification
REQ-030 Reset then write 8'hA5 with tx_busy=0 -> tx_start=1, sdata=8'hA5 two cycles later; empty=1 afterward.
REQ-031 Write 8'h01,8'h02,8'h03 back-to-back with model transmitter (busy 10 cycles per byte) -> three tx_start pulses, sdata 01,02,03 in order, each pulse after tx_busy falls.
REQ-032 DEPTH_LOG2=2, tx_busy held 1, write 5 bytes -> count=4, full=1, fifth byte dropped (ovf=1 when OVF_EN).
REQ-033 Full FIFO, release tx_busy, write on pop cycle -> write dropped, count=3 next cycle.
REQ-034 Count=2, simultaneous write and pop -> count stays 2, order preserved.
REQ-035 Assert rstn=0 in WAIT_DONE -> all outputs at reset values same cycle, FIFO empty, no tx_start after release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit buffer.
// Optional feature macro: UART_TX_BUFFER_OVF_EN (overflow flag ports).
package uart_pkg;

    localparam int DEPTH_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_fifo_sync.sv
// Single-clock FIFO with occupancy counter for the UART transmit buffer.
// Full/empty derive from the registered count; storage is not reset.
module fifo_sync
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_we,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_wr;
    logic                  w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A write while full is dropped even when a pop happens in the same cycle
    assign w_wr = i_we & ~o_full;
    assign w_rd = i_re & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Define UART_TX_BUFFER_OVF_EN to add the sticky ovf / ovf_clr ports.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [7:0]          wdata,
    input  logic                we,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic [7:0]          sdata,
    output logic                tx_start,
    input  logic                tx_busy
`ifdef UART_TX_BUFFER_OVF_EN
    ,
    output logic                ovf,
    input  logic                ovf_clr
`endif
);

    logic [7:0]          w_head;
    logic                w_full;
    logic                w_empty;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_pop;
    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic                r_tx_start;
    logic [7:0]          r_sdata;

    fifo_sync #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_we    (we),
        .i_wdata (wdata),
        .i_re    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = w_count;
    assign sdata    = r_sdata;
    assign tx_start = r_tx_start;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The start pulse is registered alongside the popped byte so both
    // reach the transmitter together on the cycle after the pop decision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_sdata    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_sdata <= w_head;
            end
        end
    end

`ifdef UART_TX_BUFFER_OVF_EN
    logic r_ovf;
    logic w_drop;

    assign w_drop = we & w_full;
    assign ovf    = r_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer (DEPTH_LOG2=2): vector table,
// handshake sequences and a randomized run against a queue model.
module tb_uart_tx_buffer;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] wdata = 8'h00;
    logic       we = 1'b0;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic [7:0] sdata;
    logic       tx_start;
    logic       tx_busy;
`ifdef UART_TX_BUFFER_OVF_EN
    logic       ovf;
    logic       ovf_clr = 1'b0;
`endif

    uart_tx_buffer #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wdata    (wdata),
        .we       (we),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
`ifdef UART_TX_BUFFER_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for m_len cycles starting the cycle after
    // it samples tx_start.
    logic auto_busy = 1'b0;
    logic man_busy  = 1'b0;
    int   m_len     = 10;
    int   m_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn)           m_cnt <= 0;
        else if (tx_start)   m_cnt <= m_len;
        else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end

    assign tx_busy = auto_busy ? (m_cnt != 0) : man_busy;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       b;
        logic [2:0] c;
        logic       f;
        logic       e;
        logic       t;
        logic [7:0] s;
    } vec_t;

    vec_t tab[$];

    function automatic void add(logic w, logic [7:0] d, logic b,
                                logic [2:0] c, logic f, logic e,
                                logic t, logic [7:0] s);
        vec_t v;
        v = '{w, d, b, c, f, e, t, s};
        tab.push_back(v);
    endfunction

    // Behavioural reference: FIFO contents as a queue of accepted bytes
    logic [7:0] q[$];
    int         mcount = 0;

    task automatic rnd_step(input logic wen);
        int   cnt_b;
        logic busy_b;
        logic txs_b;
        logic acc;
        we     = wen;
        wdata  = 8'($urandom);
        m_len  = $urandom_range(1, 6);
        cnt_b  = mcount;
        busy_b = tx_busy;
        txs_b  = tx_start;
        tick();
        acc = wen && (cnt_b < DEPTH);
        if (tx_start) begin
            chk("rnd_pop_legal",
                {29'd0, cnt_b > 0, !busy_b, !txs_b}, 32'd7);
            if (q.size() > 0) begin
                chk("rnd_order", sdata, q.pop_front());
                mcount--;
            end
        end
        if (acc) begin
            q.push_back(wdata);
            mcount++;
        end
        chk("rnd_count", count, mcount);
        chk("rnd_full", full, mcount == DEPTH);
        chk("rnd_empty", empty, mcount == 0);
    endtask

    initial begin
        int   k;
        logic busy_b;
        int   seen;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_sdata", sdata, 8'h00);
        chk("rst_txs", tx_start, 0);
        rstn = 1'b1;

        add(1, 8'hA5, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 1, 1, 8'hA5);
        add(0, 8'h00, 0, 0, 0, 1, 0, 8'hA5);
        add(0, 8'h00, 1, 0, 0, 1, 0, 8'hA5);
        add(1, 8'h11, 1, 1, 0, 0, 0, 8'hA5);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'hA5);
        add(0, 8'h00, 0, 0, 0, 1, 1, 8'h11);
        add(0, 8'h00, 0, 0, 0, 1, 0, 8'h11);
        add(0, 8'h00, 1, 0, 0, 1, 0, 8'h11);
        add(0, 8'h00, 0, 0, 0, 1, 0, 8'h11);
        add(1, 8'h21, 1, 1, 0, 0, 0, 8'h11);
        add(1, 8'h22, 1, 2, 0, 0, 0, 8'h11);
        add(1, 8'h23, 1, 3, 0, 0, 0, 8'h11);
        add(1, 8'h24, 1, 4, 1, 0, 0, 8'h11);
        add(1, 8'h25, 1, 4, 1, 0, 0, 8'h11);
        add(1, 8'h26, 0, 3, 0, 0, 1, 8'h21);
        add(0, 8'h00, 0, 3, 0, 0, 0, 8'h21);
        add(0, 8'h00, 1, 3, 0, 0, 0, 8'h21);
        add(0, 8'h00, 0, 3, 0, 0, 0, 8'h21);
        add(0, 8'h00, 0, 2, 0, 0, 1, 8'h22);
        add(0, 8'h00, 0, 2, 0, 0, 0, 8'h22);
        add(0, 8'h00, 1, 2, 0, 0, 0, 8'h22);
        add(0, 8'h00, 0, 2, 0, 0, 0, 8'h22);
        add(1, 8'h27, 0, 2, 0, 0, 1, 8'h23);
        add(0, 8'h00, 0, 2, 0, 0, 0, 8'h23);
        add(0, 8'h00, 1, 2, 0, 0, 0, 8'h23);
        add(0, 8'h00, 0, 2, 0, 0, 0, 8'h23);
        add(0, 8'h00, 0, 1, 0, 0, 1, 8'h24);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'h24);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h24);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'h24);
        add(0, 8'h00, 0, 0, 0, 1, 1, 8'h27);
        add(0, 8'h00, 0, 0, 0, 1, 0, 8'h27);
        add(0, 8'h00, 1, 0, 0, 1, 0, 8'h27);
        add(0, 8'h00, 0, 0, 0, 1, 0, 8'h27);
        add(0, 8'h00, 0, 0, 0, 1, 0, 8'h27);

        foreach (tab[i]) begin
            we       = tab[i].w;
            wdata    = tab[i].d;
            man_busy = tab[i].b;
            tick();
            chk($sformatf("tab%0d_count", i), count, tab[i].c);
            chk($sformatf("tab%0d_full", i), full, tab[i].f);
            chk($sformatf("tab%0d_empty", i), empty, tab[i].e);
            chk($sformatf("tab%0d_txs", i), tx_start, tab[i].t);
            chk($sformatf("tab%0d_sdata", i), sdata, tab[i].s);
        end
        we = 1'b0;

`ifdef UART_TX_BUFFER_OVF_EN
        chk("ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
`endif

        // Three back-to-back writes against the 10-cycle transmitter
        auto_busy = 1'b1;
        m_len     = 10;
        k         = 0;
        for (int c = 0; c < 200; c++) begin
            we     = (c < 3);
            wdata  = 8'(c + 1);
            busy_b = tx_busy;
            tick();
            if (tx_start) begin
                if (k < 3) chk("seq3_sdata", sdata, k + 1);
                chk("seq3_busy_low", busy_b, 0);
                k++;
            end
        end
        we = 1'b0;
        chk("seq3_pulses", k, 3);
        chk("seq3_empty", empty, 1);

        // Reset while the FSM waits for the transmitter to finish
        we = 1'b1;
        wdata = 8'h44;
        tick();
        wdata = 8'h55;
        tick();
        we = 1'b0;
        k = 0;
        while (tx_busy !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("rstmid_busy_seen", tx_busy, 1);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_count", count, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_full", full, 0);
        chk("rstmid_sdata", sdata, 8'h00);
        chk("rstmid_txs", tx_start, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        repeat (15) begin
            tick();
            if (tx_start) seen++;
        end
        chk("rstmid_no_start", seen, 0);
        chk("rstmid_still_empty", empty, 1);
        we = 1'b1;
        wdata = 8'h66;
        tick();
        we = 1'b0;
        chk("rstmid_lat1", tx_start, 0);
        tick();
        chk("rstmid_lat2", tx_start, 1);
        chk("rstmid_new_sdata", sdata, 8'h66);
        repeat (20) tick();

        // Randomized traffic with variable busy length
        for (int i = 0; i < 400; i++) begin
            rnd_step($urandom_range(0, 9) < 6);
        end
        k = 0;
        while ((q.size() != 0 || mcount != 0) && k < 500) begin
            rnd_step(1'b0);
            k++;
        end
        chk("rnd_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
